img_window_gen: RTL and testbench

IMG_WINDOW_GEN -- requirements
Module: img_window_gen

---
 rtl/img_window_gen_pkg.sv | 14 +
 rtl/img_line_buf.sv | 24 ++
 rtl/img_window_gen.sv | 188 ++++++++++++++++++
 tb/tb_img_window_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_window_gen_pkg.sv
// Shared types and constants for the sliding-window generator.
package img_window_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MODE_INTERIOR = 0;
  localparam int MODE_ZEROFILL = 1;

endpackage

// File: rtl/img_line_buf.sv
// One-row delay line: read-before-write at the same column address.
module img_line_buf
  import img_window_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 258
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wr_data,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  // Old content leaves as new content enters, giving exactly DEPTH steps of delay.
  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wr_data;
  end

endmodule

// File: rtl/img_window_gen.sv
// Raster-scans a frame from a zero-wait memory and emits K x K pixel windows
// around each centre, with interior-only or zero-filled border handling.
module img_window_gen
  import img_window_gen_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DW    = 8,
  parameter int R     = 2,
  parameter int MODE  = MODE_INTERIOR,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic [AW-1:0]                    in_addr,
  input  logic [DW-1:0]                    in_data,
  output logic                             win_valid,
  output logic [AW-1:0]                    win_addr,
  output logic [(2*R+1)*(2*R+1)*DW-1:0]    win_data,
  output logic                             finish
);

  localparam int K   = 2*R+1;
  localparam int NLB = 2*R;
  localparam int CW  = $clog2(IMG_W+R);
  localparam int RW  = $clog2(IMG_H+R);

  state_e                          state_q, state_d;
  logic [RW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [AW-1:0]                   in_addr_q, in_addr_d;
  logic [K-1:0][K-1:0][DW-1:0]     win_q, win_d, win_sh, win_m;
  logic [K-1:0][K-1:0][DW-1:0]     win_data_q, win_data_d;
  logic                            win_valid_q, win_valid_d;
  logic [AW-1:0]                   win_addr_q, win_addr_d;
  logic                            finish_q, finish_d;
  logic                            step;
  logic                            in_img;
  logic                            centre_ok;
  logic [DW-1:0]                   pix;
  logic [NLB-1:0][DW-1:0]          lb_in, lb_out;
  int                              r_i, c_i;

  assign r_i    = int'(row_q);
  assign c_i    = int'(col_q);
  assign in_img = (r_i < IMG_H) && (c_i < IMG_W);
  assign pix    = in_img ? in_data : '0;

  // Line buffers chained so lb_out[k] is the pixel k+1 rows above the current one.
  assign lb_in[0] = pix;
  for (genvar g = 0; g < NLB; g++) begin : g_lb
    if (g > 0) begin : g_chain
      assign lb_in[g] = lb_out[g-1];
    end
    img_line_buf #(
      .DW    (DW),
      .DEPTH (IMG_W+R)
    ) u_lb (
      .clk     (clk),
      .we      (step),
      .addr    (col_q),
      .wr_data (lb_in[g]),
      .rd_data (lb_out[g])
    );
  end

  always_comb begin
    win_sh = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) win_sh[i][j] = win_q[i][j+1];
    end
    for (int i = 0; i < K-1; i++) win_sh[i][K-1] = lb_out[K-2-i];
    win_sh[K-1][K-1] = pix;
  end

  // Zero-fill masks by true image coordinate, so stale buffer or wrap-around data never shows.
  always_comb begin
    int pr, pc;
    win_m = win_sh;
    pr    = 0;
    pc    = 0;
    if (MODE == MODE_ZEROFILL) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          pr = r_i - 2*R + i;
          pc = c_i - 2*R + j;
          if (pr < 0 || pr >= IMG_H || pc < 0 || pc >= IMG_W) win_m[i][j] = '0;
        end
      end
    end
  end

  always_comb begin
    centre_ok = 1'b0;
    if (MODE == MODE_ZEROFILL)
      centre_ok = (r_i >= R) && (c_i >= R);
    else
      centre_ok = (r_i >= 2*R) && (r_i <= IMG_H-1) && (c_i >= 2*R) && (c_i <= IMG_W-1);
  end

  always_comb begin
    int nr, nc;
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    in_addr_d   = in_addr_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_addr_d  = win_addr_q;
    win_data_d  = win_data_q;
    finish_d    = 1'b0;
    step        = 1'b0;
    nr          = r_i;
    nc          = c_i;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SCAN;
          row_d     = '0;
          col_d     = '0;
          in_addr_d = '0;
        end
      end
      ST_SCAN: begin
        if (in_valid) begin
          step  = 1'b1;
          win_d = win_sh;
          if (c_i == IMG_W+R-1) begin
            nr = r_i + 1;
            nc = 0;
          end else begin
            nc = c_i + 1;
          end
          if (nr == IMG_H+R) begin
            state_d = ST_DRAIN;
          end else begin
            row_d = RW'(nr);
            col_d = CW'(nc);
            if (nr < IMG_H && nc < IMG_W) in_addr_d = AW'(nr*IMG_W + nc);
          end
          if (centre_ok) begin
            win_valid_d = 1'b1;
            win_addr_d  = AW'((r_i-R)*IMG_W + (c_i-R));
            win_data_d  = win_m;
          end
        end
      end
      ST_DRAIN: begin
        state_d  = ST_DONE;
        finish_d = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      in_addr_q   <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_addr_q  <= '0;
      win_data_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      in_addr_q   <= in_addr_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_addr_q  <= win_addr_d;
      win_data_q  <= win_data_d;
      finish_q    <= finish_d;
    end
  end

  assign in_addr   = in_addr_q;
  assign win_valid = win_valid_q;
  assign win_addr  = win_addr_q;
  assign win_data  = win_data_q;
  assign finish    = finish_q;

endmodule

// File: tb/tb_img_window_gen.sv
// Directed bench: 8x6 frame, R=1, mem[a]=a, both border modes side by side.
module tb_img_window_gen;
  import img_window_gen_pkg::*;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int R  = 1;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int AW = 6;
  localparam int WD = K*K*DW;
  localparam int NV = 19;

  logic          clk = 1'b0;
  logic          rst, in_valid;
  logic [AW-1:0] in_addr0, in_addr1, win_addr0, win_addr1;
  logic [DW-1:0] in_data0, in_data1;
  logic          win_valid0, win_valid1, finish0, finish1;
  logic [WD-1:0] win_data0, win_data1;

  always #5 clk = ~clk;

  assign in_data0 = DW'(in_addr0);
  assign in_data1 = DW'(in_addr1);

  img_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .R(R), .MODE(MODE_INTERIOR)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr0), .in_data(in_data0),
    .win_valid(win_valid0), .win_addr(win_addr0), .win_data(win_data0), .finish(finish0));

  img_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .R(R), .MODE(MODE_ZEROFILL)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr1), .in_data(in_data1),
    .win_valid(win_valid1), .win_addr(win_addr1), .win_data(win_data1), .finish(finish1));

  typedef struct {
    logic [AW-1:0] addr;
    logic [WD-1:0] data;
  } rec_t;

  typedef struct {
    int mode;
    int addr;
    int i;
    int j;
    int exp;
  } vec_t;

  rec_t q0[$];
  rec_t q1[$];
  vec_t vt [NV];
  int   cyc = 0;
  int   fin_cnt = 0, fin_cyc = 0, last_cyc = 0;
  int   errs = 0, checks = 0;
  int   start, f1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid0) q0.push_back('{win_addr0, win_data0});
    if (win_valid1) begin
      q1.push_back('{win_addr1, win_data1});
      last_cyc <= cyc;
    end
    if (finish0) begin
      fin_cnt <= fin_cnt + 1;
      fin_cyc <= cyc;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [WD-1:0] exp_win(int y, int x);
    logic [WD-1:0] w;
    int pr, pc;
    w = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        pr = y - R + i;
        pc = x - R + j;
        if (pr >= 0 && pr < H && pc >= 0 && pc < W) w[(i*K+j)*DW +: DW] = DW'(pr*W + pc);
      end
    end
    return w;
  endfunction

  task automatic check_frame(int mode, string tag);
    rec_t q[$];
    int y0, y1, x0, x1, n;
    if (mode == 0) begin
      q = q0; y0 = R; y1 = H-1-R; x0 = R; x1 = W-1-R;
    end else begin
      q = q1; y0 = 0; y1 = H-1; x0 = 0; x1 = W-1;
    end
    chk({tag, " window count"}, q.size(), (y1-y0+1)*(x1-x0+1));
    n = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (n < q.size()) begin
          checks++;
          if (q[n].addr !== AW'(y*W + x) || q[n].data !== exp_win(y, x)) begin
            errs++;
            $display("FAIL %s window %0d: got addr %0d data %h expected addr %0d data %h",
                     tag, n, q[n].addr, q[n].data, y*W + x, exp_win(y, x));
          end
        end
        n++;
      end
    end
  endtask

  task automatic wait_finish(string nm);
    int base, k;
    base = fin_cnt;
    k = 0;
    while (fin_cnt == base && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    checks++;
    if (fin_cnt == base) begin
      errs++;
      $display("FAIL %s: got no finish within %0d cycles expected one", nm, k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] got;
    vt = '{
      '{0,  9, 0, 0,  0}, '{0,  9, 1, 1,  9}, '{0, 38, 1, 1, 38}, '{0, 38, 2, 2, 47},
      '{1,  0, 0, 0,  0}, '{1,  0, 0, 2,  0}, '{1,  0, 2, 0,  0}, '{1,  0, 1, 1,  0},
      '{1,  0, 2, 2,  9}, '{1, 47, 2, 0,  0}, '{1, 47, 0, 2,  0}, '{1, 47, 1, 1, 47},
      '{1, 47, 0, 0, 38}, '{1,  8, 0, 0,  0}, '{1,  8, 1, 0,  0}, '{1,  8, 2, 0,  0},
      '{1,  8, 1, 1,  8}, '{1,  8, 0, 1,  0}, '{1,  8, 0, 2,  1}
    };

    // Reset with in_valid high: reset must win.
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_addr", in_addr0, 0);
    chk("rst win_valid0", win_valid0, 0);
    chk("rst win_valid1", win_valid1, 0);
    chk("rst win_addr", win_addr0, 0);
    chk("rst win_data", (win_data0 === '0) ? 0 : 1, 0);
    chk("rst finish", finish0, 0);

    // Abort at scan step 20.
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort step20 in_addr", in_addr0, 18);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort in_addr", in_addr0, 0);
    chk("abort win_valid0", win_valid0, 0);
    chk("abort win_valid1", win_valid1, 0);
    chk("abort finish", finish0, 0);
    repeat (80) @(negedge clk);
    chk("abort no finish", fin_cnt, 0);

    // Full frame, in_valid held high.
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    start = cyc;
    in_valid = 1'b1;
    wait_finish("frame");
    in_valid = 1'b0;
    chk("finish latency", fin_cyc - start, 65);
    chk("last window cycle", last_cyc - start, 64);
    @(negedge clk);
    chk("finish one cycle", fin_cnt, 1);
    check_frame(0, "m0 frame");
    check_frame(1, "m1 frame");
    chk("m0 first addr", q0[0].addr, 9);
    chk("m0 last addr", q0[q0.size()-1].addr, 38);

    for (int k = 0; k < NV; k++) begin
      got = 'x;
      if (vt[k].mode == 0) begin
        foreach (q0[m]) if (int'(q0[m].addr) == vt[k].addr) got = q0[m].data[(vt[k].i*K+vt[k].j)*DW +: DW];
      end else begin
        foreach (q1[m]) if (int'(q1[m].addr) == vt[k].addr) got = q1[m].data[(vt[k].i*K+vt[k].j)*DW +: DW];
      end
      chk($sformatf("vec%0d mode%0d addr%0d el(%0d,%0d)", k, vt[k].mode, vt[k].addr, vt[k].i, vt[k].j),
          got, vt[k].exp);
    end

    // Five-cycle stall at scan step 30.
    repeat (3) @(posedge clk);
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    start = cyc;
    in_valid = 1'b1;
    repeat (31) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pause in_addr", in_addr0, 27);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk("pause in_addr hold", in_addr0, 27);
      chk("pause no window", win_valid0 | win_valid1, 0);
    end
    @(posedge clk); #1 in_valid = 1'b1;
    @(negedge clk);
    chk("resume no window", win_valid0 | win_valid1, 0);
    chk("resume in_addr", in_addr0, 27);
    wait_finish("pause frame");
    in_valid = 1'b0;
    chk("pause finish latency", fin_cyc - start, 70);
    check_frame(0, "m0 pause");
    check_frame(1, "m1 pause");

    // Back-to-back frames with in_valid never dropped.
    repeat (3) @(posedge clk);
    q0.delete(); q1.delete();
    @(posedge clk); #1 in_valid = 1'b1;
    wait_finish("b2b first");
    f1 = fin_cyc;
    q0.delete(); q1.delete();
    wait_finish("b2b second");
    in_valid = 1'b0;
    chk("b2b restart latency", fin_cyc - f1, 66);
    check_frame(0, "m0 b2b");
    check_frame(1, "m1 b2b");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
